keyboard_scanner: RTL and testbench

Memory-mapped 4x4 matrix keypad scanner. It is the input-side counterpart of the seven-segment display peripheral on the same I/O bus. The block drives keypad columns low one at a time, debounces row returns, and encodes a single pressed key into a 4-bit code. The CPU reads the code and status over the 16-bit I/O bus.

---
 rtl/keyboard_scanner_pkg.sv | 33 +++
 rtl/keyboard_scanner_scan_tick_gen.sv | 26 ++
 rtl/keyboard_scanner.sv | 133 +++++++++++++
 tb/tb_keyboard_scanner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/keyboard_scanner_pkg.sv
// Shared definitions for the keypad scanner: bus register map, scan FSM
// encoding, column reset value and a row/column one-cold decoder.
package keyboard_scanner_pkg;

  // Register addresses, aligned with the display block's 000/010/100 map
  localparam logic [2:0] KEY_DATA_ADDR   = 3'b000;
  localparam logic [2:0] KEY_STATUS_ADDR = 3'b010;

  // First column driven after reset (column 0 low)
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_CAPTURE      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } scan_state_e;

  // Returns {valid, index}: valid when exactly one bit of v is 0,
  // index is the position of that 0 bit.
  function automatic logic [2:0] decode_one_cold(input logic [3:0] v);
    logic [2:0] res;
    case (v)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keyboard_scanner_scan_tick_gen.sv
// Free-running divider: tick pulses for one cycle every DIV clocks.
// Shared with the display refresh logic.
module scan_tick_gen #(
  parameter logic [15:0] DIV = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [15:0] count;

  // Down-counter that reloads DIV-1 after reaching zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= DIV - 16'd1;
    end else if (count == 16'd0) begin
      count <= DIV - 16'd1;
    end else begin
      count <= count - 16'd1;
    end
  end

  assign tick = (count == 16'd0);

endmodule

// File: rtl/keyboard_scanner.sv
// 4x4 matrix keypad scanner on the 16-bit I/O bus. Rotates an active-low
// column drive, debounces the row returns and latches a single pressed key
// as {row, col}. debug_state exposes the scan FSM for observation.
module keyboard_scanner
  import keyboard_scanner_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_TICKS = 4'd10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [2:0]  address,
  output logic [15:0] read_data_out,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_pending,
  output logic [1:0]  debug_state
);

  logic [3:0]  row_m;
  logic [3:0]  row_s;
  logic        tick;
  scan_state_e state;
  logic [3:0]  snapshot;
  logic [3:0]  cnt;
  logic [3:0]  key_data;
  logic        pending;
  logic        overrun;
  logic [2:0]  row_dec;
  logic [2:0]  col_dec;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous keypad rows (idle high)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  assign row_dec     = decode_one_cold(snapshot);
  assign col_dec     = decode_one_cold(col);
  assign key_pending = pending;
  assign debug_state = state;

  // Scan FSM plus bus register file; a capture set overrides a read clear
  // on the same edge because it is assigned later in this block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_SCAN;
      col           <= COL_RESET;
      snapshot      <= 4'hF;
      cnt           <= 4'd0;
      key_data      <= 4'd0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      read_data_out <= 16'h0000;
    end else begin
      if (read_enable) begin
        case (address)
          KEY_DATA_ADDR: begin
            read_data_out <= {12'b0, key_data};
            pending       <= 1'b0;
          end
          KEY_STATUS_ADDR: begin
            read_data_out <= {14'b0, overrun, pending};
            overrun       <= 1'b0;
          end
          default: read_data_out <= 16'h0000;
        endcase
      end

      case (state)
        ST_SCAN: begin
          if (tick) begin
            if (row_s == 4'hF) begin
              col <= {col[2:0], col[3]};
            end else begin
              snapshot <= row_s;
              cnt      <= 4'd0;
              state    <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tick) begin
            if (row_s != snapshot) begin
              state <= ST_SCAN;
            end else if (cnt == DEBOUNCE_TICKS - 4'd1) begin
              state <= ST_CAPTURE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ST_CAPTURE: begin
          if (row_dec[2]) begin
            key_data <= {row_dec[1:0], col_dec[1:0]};
            pending  <= 1'b1;
            if (pending) begin
              overrun <= 1'b1;
            end
          end
          cnt   <= 4'd0;
          state <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (tick) begin
            if (row_s != 4'hF) begin
              cnt <= 4'd0;
            end else if (cnt == DEBOUNCE_TICKS - 4'd1) begin
              cnt   <= 4'd0;
              state <= ST_SCAN;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_scanner.sv
// Directed bench for keyboard_scanner with a simple keypad matrix model.
module tb_keyboard_scanner;

  logic        clock;
  logic        reset;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] read_data_out;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_pending;
  logic [1:0]  debug_state;

  // Pressed keys, index r*4+c
  logic [15:0] keys;

  int n_checks;
  int n_pass;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  keyboard_scanner #(
    .SCAN_DIV       (16'd4),
    .DEBOUNCE_TICKS (4'd3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .read_enable   (read_enable),
    .address       (address),
    .read_data_out (read_data_out),
    .row           (row),
    .col           (col),
    .key_pending   (key_pending),
    .debug_state   (debug_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad: a row reads low when a pressed key sits on the driven column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [15:0] exp, input string tag);
    @(negedge clock);
    read_enable = 1'b1;
    address     = addr;
    @(negedge clock);
    read_enable = 1'b0;
    address     = 3'b000;
    check(tag, read_data_out, exp);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (debug_state == s) break;
      @(negedge clock);
    end
    check(tag, {14'b0, debug_state}, {14'b0, s});
  endtask

  task automatic wait_pending(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (key_pending) break;
      @(negedge clock);
    end
    check(tag, {15'b0, key_pending}, 16'h0001);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [3:0] col_before;
    n_checks    = 0;
    n_pass      = 0;
    keys        = 16'h0000;
    read_enable = 1'b0;
    address     = 3'b000;
    reset       = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state
    check("reset_col", {12'b0, col}, 16'h000E);
    check("reset_rdata", read_data_out, 16'h0000);
    check("reset_pending", {15'b0, key_pending}, 16'h0000);
    bus_read(3'b010, 16'h0000, "reset_status");
    bus_read(3'b100, 16'h0000, "unmapped_addr");

    // Single key row 1 / col 2 -> code 0x6
    keys[1*4+2] = 1'b1;
    wait_pending(200, "press6_pending");
    check("press6_col_frozen", {12'b0, col}, 16'h000B);
    bus_read(3'b000, 16'h0006, "press6_data");
    check("press6_pending_clr", {15'b0, key_pending}, 16'h0000);
    idle(20);
    check("press6_no_recapture", {15'b0, key_pending}, 16'h0000);
    keys = 16'h0000;
    wait_state(S_SCAN, 100, "press6_back_scan");

    // Bounce: held for two ticks only
    keys[1*4+2] = 1'b1;
    wait_state(S_DEBOUNCE, 200, "bounce_enter");
    idle(5);
    keys = 16'h0000;
    wait_state(S_SCAN, 40, "bounce_abort");
    idle(1);
    col_before = col;
    idle(4);
    check("bounce_col_rotates", {12'b0, col}, {12'b0, col_before[2:0], col_before[3]});
    idle(40);
    check("bounce_no_pending", {15'b0, key_pending}, 16'h0000);
    bus_read(3'b010, 16'h0000, "bounce_status");

    // Two presses without a read -> overrun
    keys[1*4+2] = 1'b1;
    wait_pending(200, "dbl_first_pending");
    keys = 16'h0000;
    wait_state(S_SCAN, 100, "dbl_first_release");
    keys[2*4+3] = 1'b1;
    idle(2);
    wait_state(S_WAIT_REL, 200, "dbl_second_capture");
    keys = 16'h0000;
    wait_state(S_SCAN, 100, "dbl_second_release");
    bus_read(3'b010, 16'h0003, "dbl_status_ovr");
    bus_read(3'b010, 16'h0001, "dbl_status_reread");
    bus_read(3'b000, 16'h000B, "dbl_data");
    bus_read(3'b010, 16'h0000, "dbl_status_clear");

    // Two rows on one column -> discarded
    keys[0*4+1] = 1'b1;
    keys[3*4+1] = 1'b1;
    idle(2);
    wait_state(S_WAIT_REL, 200, "multi_wait_release");
    check("multi_no_pending", {15'b0, key_pending}, 16'h0000);
    bus_read(3'b000, 16'h000B, "multi_data_kept");
    keys = 16'h0000;
    wait_state(S_SCAN, 100, "multi_back_scan");
    bus_read(3'b010, 16'h0000, "multi_status");

    // Reset while debouncing a held key
    keys[1*4+2] = 1'b1;
    wait_state(S_DEBOUNCE, 200, "rst_enter_debounce");
    reset = 1'b1;
    #1;
    check("rst_col", {12'b0, col}, 16'h000E);
    check("rst_pending", {15'b0, key_pending}, 16'h0000);
    check("rst_state", {14'b0, debug_state}, {14'b0, S_SCAN});
    idle(2);
    reset = 1'b0;
    idle(20);
    check("rst_latency_early", {15'b0, key_pending}, 16'h0000);
    wait_pending(100, "rst_recapture");
    bus_read(3'b000, 16'h0006, "rst_data");
    keys = 16'h0000;
    wait_state(S_SCAN, 100, "rst_back_scan");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
